// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder built from two half_adder cells,
// stepped LSB-first over WIDTH cycles by a start/done controller.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] ra, rb, racc;
    logic [WIDTH-1:0] acc_nx;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s1, c1, bs, c2, nc;
    logic             last;

    half_adder u_ha0 (
        .a    (ra[0]),
        .b    (rb[0]),
        .sum  (s1),
        .carry(c1)
    );

    half_adder u_ha1 (
        .a    (s1),
        .b    (c),
        .sum  (bs),
        .carry(c2)
    );

    assign nc     = c1 | c2;
    assign acc_nx = {bs, racc[WIDTH-1:1]};
    assign last   = (cnt == CW'(WIDTH - 1));

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The final shift edge also publishes the result, so sum/cout
    // include the bit computed in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            racc <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra   <= a;
                        rb   <= b;
                        racc <= '0;
                        c    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    racc <= acc_nx;
                    ra   <= {1'b0, ra[WIDTH-1:1]};
                    rb   <= {1'b0, rb[WIDTH-1:1]};
                    c    <= nc;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        sum  <= acc_nx;
                        cout <= nc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
